// File: rtl/ndp_stream_sequencer.sv
// ndp_stream_sequencer: unpacks a 32-bit AXI-Stream of activation columns and
// weight rows into one K-step at a time, hands each step to the systolic array,
// and requests a result drain once the last K-step of a job is accepted.
module ndp_stream_sequencer #(
  parameter int WIDTH   = 16,
  parameter int A_ROWS  = 4,
  parameter int B_COLS  = 64,
  parameter int K_DEPTH = 21
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               s_axis_tdata,
  input  logic                      s_axis_tvalid,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  output logic [A_ROWS*WIDTH-1:0]   act_col,
  output logic [B_COLS*WIDTH-1:0]   wgt_row,
  output logic                      step_valid,
  output logic                      step_first,
  output logic                      step_last,
  input  logic                      step_ready,
  output logic                      drain_start,
  input  logic                      drain_done,
  output logic                      busy,
  output logic                      err_tlast,
  input  logic                      err_clr
);

  localparam int AW   = A_ROWS * WIDTH / 32;
  localparam int BW   = B_COLS * WIDTH / 32;
  localparam int MAXW = (AW > BW) ? AW : BW;
  localparam int WCW  = $clog2(MAXW + 1);
  localparam int KW   = $clog2(K_DEPTH + 1);

  // Column and row widths must split into whole 32-bit stream words.
  generate
    if (((A_ROWS * WIDTH) % 32) != 0 || ((B_COLS * WIDTH) % 32) != 0 ||
        AW < 1 || BW < 1 || K_DEPTH < 1) begin : g_param_check
      $error("ndp_stream_sequencer: A_ROWS*WIDTH and B_COLS*WIDTH must be nonzero multiples of 32");
    end
  endgenerate

  typedef enum logic [1:0] {RECV_A, RECV_B, ISSUE, DRAIN} state_t;

  state_t           state;
  logic [WCW-1:0]   word;
  logic [KW-1:0]    k;
  logic             accept;
  logic             last_col;
  logic             last_row;
  logic             final_k;
  logic             job_final;
  logic             err_set;

  assign s_axis_tready = (state == RECV_A) || (state == RECV_B);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign last_col      = (word == WCW'(AW - 1));
  assign last_row      = (word == WCW'(BW - 1));
  assign final_k       = (k == KW'(K_DEPTH - 1));
  assign job_final     = last_row && final_k;
  assign busy          = !((state == RECV_A) && (k == '0) && (word == '0));

  // Framing check: tlast must appear on exactly the job-final row beat.
  always_comb begin
    err_set = 1'b0;
    if (accept) begin
      if (state == RECV_A)
        err_set = s_axis_tlast;
      else if (state == RECV_B)
        err_set = job_final ? !s_axis_tlast : s_axis_tlast;
    end
  end

  // Main sequencer: receive column, receive row, issue step, drain at job end.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RECV_A;
      k           <= '0;
      word        <= '0;
      act_col     <= '0;
      wgt_row     <= '0;
      step_valid  <= 1'b0;
      step_first  <= 1'b0;
      step_last   <= 1'b0;
      drain_start <= 1'b0;
    end else begin
      case (state)
        RECV_A: begin
          if (accept) begin
            for (int w = 0; w < AW; w++)
              if (word == WCW'(w)) act_col[32*w +: 32] <= s_axis_tdata;
            if (s_axis_tlast) begin
              k    <= '0;
              word <= '0;
            end else if (last_col) begin
              state <= RECV_B;
              word  <= '0;
            end else begin
              word <= word + WCW'(1);
            end
          end
        end
        RECV_B: begin
          if (accept) begin
            for (int w = 0; w < BW; w++)
              if (word == WCW'(w)) wgt_row[32*w +: 32] <= s_axis_tdata;
            if (s_axis_tlast && !job_final) begin
              state <= RECV_A;
              k     <= '0;
              word  <= '0;
            end else if (last_row) begin
              state      <= ISSUE;
              word       <= '0;
              step_valid <= 1'b1;
              step_first <= (k == '0);
              step_last  <= final_k;
            end else begin
              word <= word + WCW'(1);
            end
          end
        end
        ISSUE: begin
          if (step_ready) begin
            step_valid <= 1'b0;
            step_first <= 1'b0;
            step_last  <= 1'b0;
            if (final_k) begin
              state       <= DRAIN;
              drain_start <= 1'b1;
            end else begin
              k     <= k + KW'(1);
              state <= RECV_A;
            end
          end
        end
        DRAIN: begin
          drain_start <= 1'b0;
          if (drain_done) begin
            state <= RECV_A;
            k     <= '0;
          end
        end
        default: state <= RECV_A;
      endcase
    end
  end

  // Sticky framing error; a new error outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset)
      err_tlast <= 1'b0;
    else if (err_set)
      err_tlast <= 1'b1;
    else if (err_clr)
      err_tlast <= 1'b0;
  end

endmodule

// File: tb/tb_ndp_stream_sequencer.sv
// tb_ndp_stream_sequencer: directed scenarios for the stream sequencer with
// hand-derived data patterns and step timing.
module tb_ndp_stream_sequencer;

  localparam int WIDTH   = 16;
  localparam int A_ROWS  = 4;
  localparam int B_COLS  = 64;
  localparam int K_DEPTH = 21;
  localparam int AW      = A_ROWS * WIDTH / 32;
  localparam int BW      = B_COLS * WIDTH / 32;
  localparam int AWID    = A_ROWS * WIDTH;
  localparam int BWID    = B_COLS * WIDTH;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      s_axis_tdata;
  logic             s_axis_tvalid;
  logic             s_axis_tlast;
  logic             s_axis_tready;
  logic [AWID-1:0]  act_col;
  logic [BWID-1:0]  wgt_row;
  logic             step_valid;
  logic             step_first;
  logic             step_last;
  logic             step_ready;
  logic             drain_start;
  logic             drain_done;
  logic             busy;
  logic             err_tlast;
  logic             err_clr;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int drain_cnt = 0;

  int              step_cyc[$];
  logic [AWID-1:0] step_act[$];
  logic [BWID-1:0] step_wgt[$];
  logic            step_fst[$];
  logic            step_lst[$];

  ndp_stream_sequencer #(
    .WIDTH(WIDTH), .A_ROWS(A_ROWS), .B_COLS(B_COLS), .K_DEPTH(K_DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .act_col(act_col), .wgt_row(wgt_row),
    .step_valid(step_valid), .step_first(step_first), .step_last(step_last),
    .step_ready(step_ready),
    .drain_start(drain_start), .drain_done(drain_done),
    .busy(busy), .err_tlast(err_tlast), .err_clr(err_clr)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Log every step handshake and drain pulse, sampled mid-cycle
  always @(negedge clk) begin
    cycle = cycle + 1;
    if (step_valid && step_ready) begin
      step_cyc.push_back(cycle);
      step_act.push_back(act_col);
      step_wgt.push_back(wgt_row);
      step_fst.push_back(step_first);
      step_lst.push_back(step_last);
    end
    if (drain_start) drain_cnt = drain_cnt + 1;
  end

  // Safety net so the run always terminates
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] col_word(input int kk, input int w);
    logic [7:0]  kb;
    logic [15:0] wb;
    if (kk == 0) return (w == 0) ? 32'h3C003C00 : 32'h40004000;
    kb = kk[7:0];
    wb = w[15:0];
    return {8'hA0, kb, wb};
  endfunction

  function automatic logic [31:0] row_word(input int kk, input int w);
    logic [7:0]  kb;
    logic [15:0] wb;
    kb = kk[7:0];
    wb = w[15:0];
    return {8'hB0, kb, wb};
  endfunction

  function automatic logic [AWID-1:0] exp_act(input int kk);
    logic [AWID-1:0] r;
    r = '0;
    for (int w = 0; w < AW; w++) r[32*w +: 32] = col_word(kk, w);
    return r;
  endfunction

  function automatic logic [BWID-1:0] exp_wgt(input int kk);
    logic [BWID-1:0] r;
    r = '0;
    for (int w = 0; w < BW; w++) r[32*w +: 32] = row_word(kk, w);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    step_cyc.delete();
    step_act.delete();
    step_wgt.delete();
    step_fst.delete();
    step_lst.delete();
    drain_cnt = 0;
  endtask

  task automatic do_reset();
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    drain_done    = 1'b0;
    err_clr       = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // Present one beat, optionally after an idle cycle, and hold it until accepted
  task automatic send_beat(input logic [31:0] d, input logic l, input bit gap);
    bit acc;
    int n;
    if (gap) begin
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      tick();
    end
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = s_axis_tready;
      tick();
      n++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!acc) begin
      total++; bad++;
      $display("[TB] FAIL beat_accept got=tready_low exp=accepted data=%h", d);
    end
  endtask

  task automatic send_step(input int kk, input bit gap, input bit tlast_final);
    for (int w = 0; w < AW; w++) send_beat(col_word(kk, w), 1'b0, gap);
    for (int w = 0; w < BW; w++)
      send_beat(row_word(kk, w), (w == BW-1) && (kk == K_DEPTH-1) && tlast_final, gap);
  endtask

  task automatic wait_issue();
    bit hit;
    int n;
    hit = 1'b0;
    n = 0;
    while (!hit && n < 100) begin
      @(negedge clk);
      hit = step_valid && step_ready;
      tick();
      n++;
    end
    if (!hit) begin
      total++; bad++;
      $display("[TB] FAIL issue_wait got=no_handshake exp=handshake");
    end
  endtask

  task automatic wait_drain(output bit seen);
    int n;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      seen = drain_start;
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    step_ready = 1'b0; drain_done = 1'b0; err_clr = 1'b0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    total++; if (s_axis_tready !== 1'b1) begin bad++; $display("[TB] FAIL rst_tready got=%b exp=1", s_axis_tready); end
    total++; if (step_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_step_valid got=%b exp=0", step_valid); end
    total++; if ({step_first, step_last, drain_start} !== 3'b000) begin bad++; $display("[TB] FAIL rst_flags got=%b exp=000", {step_first, step_last, drain_start}); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%b exp=0", busy); end
    total++; if (err_tlast !== 1'b0) begin bad++; $display("[TB] FAIL rst_err got=%b exp=0", err_tlast); end
    total++; if (act_col !== '0) begin bad++; $display("[TB] FAIL rst_act got=%h exp=0", act_col); end
    total++; if (wgt_row !== '0) begin bad++; $display("[TB] FAIL rst_wgt got=%h exp=0", wgt_row); end
    tick();
  endtask

  task automatic test_full_job();
    bit seen;
    do_reset();
    clear_log();
    step_ready = 1'b1;
    for (int kk = 0; kk < K_DEPTH; kk++) begin
      send_step(kk, 1'b0, 1'b1);
      wait_issue();
    end
    wait_drain(seen);
    drain_done = 1'b1;
    tick();
    drain_done = 1'b0;
    tick(); tick();
    total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL job_drain_seen got=%b exp=1", seen); end
    total++; if (step_cyc.size() !== K_DEPTH) begin bad++; $display("[TB] FAIL job_step_count got=%0d exp=%0d", step_cyc.size(), K_DEPTH); end
    total++; if (step_act[0] !== 64'h400040003C003C00) begin bad++; $display("[TB] FAIL job_act_k0 got=%h exp=400040003c003c00", step_act[0]); end
    for (int i = 0; i < step_cyc.size(); i++) begin
      total++; if (step_fst[i] !== (i == 0)) begin bad++; $display("[TB] FAIL job_first[%0d] got=%b exp=%b", i, step_fst[i], i == 0); end
      total++; if (step_lst[i] !== (i == K_DEPTH-1)) begin bad++; $display("[TB] FAIL job_last[%0d] got=%b exp=%b", i, step_lst[i], i == K_DEPTH-1); end
      total++; if (step_act[i] !== exp_act(i)) begin bad++; $display("[TB] FAIL job_act[%0d] got=%h exp=%h", i, step_act[i], exp_act(i)); end
      total++; if (step_wgt[i] !== exp_wgt(i)) begin bad++; $display("[TB] FAIL job_wgt[%0d] got=%h exp=%h", i, step_wgt[i], exp_wgt(i)); end
      if (i > 0) begin
        total++; if (step_cyc[i] - step_cyc[i-1] !== AW + BW + 1) begin bad++; $display("[TB] FAIL job_spacing[%0d] got=%0d exp=%0d", i, step_cyc[i] - step_cyc[i-1], AW + BW + 1); end
      end
    end
    total++; if (drain_cnt !== 1) begin bad++; $display("[TB] FAIL job_drain_pulses got=%0d exp=1", drain_cnt); end
    @(negedge clk);
    total++; if (err_tlast !== 1'b0) begin bad++; $display("[TB] FAIL job_err got=%b exp=0", err_tlast); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL job_idle_busy got=%b exp=0", busy); end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    clear_log();
    step_ready = 1'b0;
    send_step(0, 1'b0, 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++; if (step_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_valid[%0d] got=%b exp=1", c, step_valid); end
      total++; if (s_axis_tready !== 1'b0) begin bad++; $display("[TB] FAIL stall_tready[%0d] got=%b exp=0", c, s_axis_tready); end
      total++; if (step_first !== 1'b1) begin bad++; $display("[TB] FAIL stall_first[%0d] got=%b exp=1", c, step_first); end
      total++; if (act_col !== exp_act(0)) begin bad++; $display("[TB] FAIL stall_act[%0d] got=%h exp=%h", c, act_col, exp_act(0)); end
      total++; if (wgt_row !== exp_wgt(0)) begin bad++; $display("[TB] FAIL stall_wgt[%0d] got=%h exp=%h", c, wgt_row, exp_wgt(0)); end
      tick();
    end
    step_ready = 1'b1;
    @(negedge clk);
    total++; if (step_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_release_valid got=%b exp=1", step_valid); end
    tick();
    @(negedge clk);
    total++; if (step_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_after_valid got=%b exp=0", step_valid); end
    total++; if (s_axis_tready !== 1'b1) begin bad++; $display("[TB] FAIL stall_after_tready got=%b exp=1", s_axis_tready); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL stall_after_busy got=%b exp=1", busy); end
    tick();
    send_step(1, 1'b0, 1'b1);
    wait_issue();
    tick();
    total++; if (step_cyc.size() !== 2) begin bad++; $display("[TB] FAIL stall_step_count got=%0d exp=2", step_cyc.size()); end
    total++; if (step_fst[1] !== 1'b0) begin bad++; $display("[TB] FAIL stall_k1_first got=%b exp=0", step_fst[1]); end
    total++; if (step_act[1] !== exp_act(1)) begin bad++; $display("[TB] FAIL stall_k1_act got=%h exp=%h", step_act[1], exp_act(1)); end
    do_reset();
  endtask

  task automatic test_tlast_error();
    do_reset();
    clear_log();
    step_ready = 1'b1;
    for (int kk = 0; kk < 3; kk++) begin
      send_step(kk, 1'b0, 1'b1);
      wait_issue();
    end
    for (int w = 0; w < AW; w++) send_beat(col_word(3, w), 1'b0, 1'b0);
    for (int w = 0; w < 5; w++) send_beat(row_word(3, w), 1'b0, 1'b0);
    err_clr = 1'b1;
    send_beat(row_word(3, 5), 1'b1, 1'b0);
    err_clr = 1'b0;
    @(negedge clk);
    total++; if (err_tlast !== 1'b1) begin bad++; $display("[TB] FAIL tlast_err_set got=%b exp=1", err_tlast); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL tlast_busy got=%b exp=0", busy); end
    tick();
    for (int c = 0; c < 40; c++) tick();
    total++; if (step_cyc.size() !== 3) begin bad++; $display("[TB] FAIL tlast_step_count got=%0d exp=3", step_cyc.size()); end
    send_beat(32'h12345678, 1'b0, 1'b0);
    @(negedge clk);
    total++; if (act_col[31:0] !== 32'h12345678) begin bad++; $display("[TB] FAIL tlast_restart_word0 got=%h exp=12345678", act_col[31:0]); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL tlast_restart_busy got=%b exp=1", busy); end
    total++; if (err_tlast !== 1'b1) begin bad++; $display("[TB] FAIL tlast_err_sticky got=%b exp=1", err_tlast); end
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    @(negedge clk);
    total++; if (err_tlast !== 1'b0) begin bad++; $display("[TB] FAIL tlast_err_clr got=%b exp=0", err_tlast); end
    tick();
    do_reset();
  endtask

  task automatic test_toggle();
    do_reset();
    clear_log();
    step_ready = 1'b1;
    for (int kk = 0; kk < 3; kk++) begin
      send_step(kk, 1'b1, 1'b1);
      wait_issue();
    end
    tick();
    total++; if (step_cyc.size() !== 3) begin bad++; $display("[TB] FAIL toggle_step_count got=%0d exp=3", step_cyc.size()); end
    for (int i = 0; i < step_cyc.size(); i++) begin
      total++; if (step_act[i] !== exp_act(i)) begin bad++; $display("[TB] FAIL toggle_act[%0d] got=%h exp=%h", i, step_act[i], exp_act(i)); end
      total++; if (step_wgt[i] !== exp_wgt(i)) begin bad++; $display("[TB] FAIL toggle_wgt[%0d] got=%h exp=%h", i, step_wgt[i], exp_wgt(i)); end
      if (i > 0) begin
        total++; if (step_cyc[i] - step_cyc[i-1] !== 2*(AW + BW) + 1) begin bad++; $display("[TB] FAIL toggle_spacing[%0d] got=%0d exp=%0d", i, step_cyc[i] - step_cyc[i-1], 2*(AW + BW) + 1); end
      end
    end
    do_reset();
  endtask

  task automatic test_reset_drain();
    bit seen;
    do_reset();
    clear_log();
    step_ready = 1'b1;
    for (int kk = 0; kk < K_DEPTH; kk++) begin
      send_step(kk, 1'b0, 1'b0);
      wait_issue();
    end
    wait_drain(seen);
    @(negedge clk);
    total++; if (seen !== 1'b1) begin bad++; $display("[TB] FAIL rd_drain_seen got=%b exp=1", seen); end
    total++; if (err_tlast !== 1'b1) begin bad++; $display("[TB] FAIL rd_missing_tlast_err got=%b exp=1", err_tlast); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rd_drain_busy got=%b exp=1", busy); end
    total++; if (step_cyc.size() !== K_DEPTH) begin bad++; $display("[TB] FAIL rd_step_count got=%0d exp=%0d", step_cyc.size(), K_DEPTH); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rd_busy got=%b exp=0", busy); end
    total++; if (s_axis_tready !== 1'b1) begin bad++; $display("[TB] FAIL rd_tready got=%b exp=1", s_axis_tready); end
    total++; if (err_tlast !== 1'b0) begin bad++; $display("[TB] FAIL rd_err got=%b exp=0", err_tlast); end
    total++; if ({step_valid, drain_start} !== 2'b00) begin bad++; $display("[TB] FAIL rd_outputs got=%b exp=00", {step_valid, drain_start}); end
    total++; if (act_col !== '0) begin bad++; $display("[TB] FAIL rd_act_cleared got=%h exp=0", act_col); end
    tick();
    for (int c = 0; c < 10; c++) tick();
    total++; if (drain_cnt !== 1) begin bad++; $display("[TB] FAIL rd_drain_pulses got=%0d exp=1", drain_cnt); end
    clear_log();
    send_step(0, 1'b0, 1'b1);
    wait_issue();
    tick();
    total++; if (step_cyc.size() !== 1) begin bad++; $display("[TB] FAIL rd_fresh_count got=%0d exp=1", step_cyc.size()); end
    total++; if (step_fst[0] !== 1'b1) begin bad++; $display("[TB] FAIL rd_fresh_first got=%b exp=1", step_fst[0]); end
    total++; if (step_act[0] !== exp_act(0)) begin bad++; $display("[TB] FAIL rd_fresh_act got=%h exp=%h", step_act[0], exp_act(0)); end
    do_reset();
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_full_job();
    test_stall();
    test_tlast_error();
    test_toggle();
    test_reset_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ndp_stream_sequencer.md
NDP_STREAM_SEQUENCER -- requirements
Module: ndp_stream_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, element width in bits (fp16).
REQ-002 SHALL have parameter A_ROWS, default 4, activation elements per K-step (SYS_HEIGHT*ARR_HEIGHT).
REQ-003 SHALL have parameter B_COLS, default 64, weight elements per K-step (SYS_WIDTH*ARR_WIDTH).
REQ-004 SHALL have parameter K_DEPTH, default 21, K-steps per job (MATRIX_A_WIDTH).
REQ-005 SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port s_axis_tdata, input, 32, input stream word.
REQ-008 SHALL have ports s_axis_tvalid and s_axis_tlast, input, 1 each, AXI-Stream valid and last.
REQ-009 SHALL have port s_axis_tready, output, 1, stream ready.
REQ-010 SHALL have port act_col, output, A_ROWS*WIDTH, assembled activation column.
REQ-011 SHALL have port wgt_row, output, B_COLS*WIDTH, assembled weight row.
REQ-012 SHALL have ports step_valid, step_first and step_last, output, 1 each, K-step issue to array plus first/last-step markers.
REQ-013 SHALL have port step_ready, input, 1, array accepts step.
REQ-014 SHALL have port drain_start, output, 1, one-cycle pulse requesting result drain.
REQ-015 SHALL have port drain_done, input, 1, drain complete.
REQ-016 SHALL have ports busy and err_tlast, output, 1 each; busy is high outside idle, err_tlast is a sticky framing error.
REQ-017 SHALL have port err_clr, input, 1, clears err_tlast.

Function
REQ-018 Words per column SHALL be AW=A_ROWS*WIDTH/32 (2); words per row SHALL be BW=B_COLS*WIDTH/32 (32); both SHALL be integers, with a parameter check that fails elaboration otherwise.
REQ-019 Stream order per job SHALL be: for k=0..K_DEPTH-1, AW column words then BW row words; tlast SHALL be on the final row word of k=K_DEPTH-1.
REQ-020 The accepted word at index w SHALL be written to act_col[32*w +: 32] or wgt_row[32*w +: 32]; the lower element occupies bits [15:0].
REQ-021 States SHALL be RECV_A, RECV_B, ISSUE and DRAIN; RECV_A with k=0 and word=0 is idle.
REQ-022 s_axis_tready SHALL be 1 in RECV_A and RECV_B, and 0 in ISSUE and DRAIN.
REQ-023 A beat SHALL be accepted only when tvalid and tready are both high; the word counter SHALL advance per accepted beat only.
REQ-024 RECV_A SHALL go to RECV_B after accepting word AW-1, with the word counter reset to 0.
REQ-025 RECV_B SHALL go to ISSUE after accepting word BW-1, and step_valid SHALL be high from the next cycle.
REQ-026 In ISSUE, step_valid, act_col, wgt_row, step_first (k==0) and step_last (k==K_DEPTH-1) SHALL be held stable until step_ready is sampled high.
REQ-027 On the ISSUE handshake with k<K_DEPTH-1, the block SHALL increment k and go to RECV_A; with k==K_DEPTH-1 it SHALL go to DRAIN.
REQ-028 drain_start SHALL be high exactly during the first DRAIN cycle.
REQ-029 In DRAIN, drain_done sampled high (including the first cycle) SHALL return the block to RECV_A with k=0.
REQ-030 Minimum cycles per K-step SHALL be AW+BW+1 (35) with continuous tvalid and step_ready held high.
REQ-031 tlast accepted on any beat other than the job-final beat SHALL set err_tlast, discard the partial step (no step_valid), and return to RECV_A with k=0 and word=0.
REQ-032 A job-final beat without tlast SHALL set err_tlast, and the job SHALL otherwise complete normally.
REQ-033 err_clr SHALL clear err_tlast; if err_clr coincides with a new error, the set SHALL win.
REQ-034 busy SHALL be 0 only in RECV_A with k=0 and word=0.

Reset
REQ-035 With reset high at a clock edge, the block SHALL go to RECV_A with k=0 and word=0, from any state including mid-ISSUE and DRAIN.
REQ-036 Reset values SHALL be: s_axis_tready=1 from the first post-reset cycle; step_valid, step_first, step_last, drain_start, busy and err_tlast all 0; act_col and wgt_row all 0.
REQ-037 A partial job in progress at reset SHALL be dropped, and no step_valid or drain_start SHALL follow.

Verification
REQ-038 Full job, step_ready=1, drain_done one cycle after drain_start -> 21 step_valid pulses, first with step_first=1, last with step_last=1, each 35 cycles apart, one drain_start, err_tlast=0.
REQ-039 Column words 0x3C003C00, 0x40004000 -> act_col=0x400040003C003C00 at the k=0 issue.
REQ-040 step_ready held 0 for 10 cycles in ISSUE -> step_valid and data stable, tready=0, then advance on the first cycle step_ready=1.
REQ-041 tlast on k=3, row word 5 -> err_tlast=1, no step for k=3, next beat stored as act_col word 0 of k=0; err_clr -> err_tlast=0.
REQ-042 reset asserted in DRAIN before drain_done -> RECV_A, busy=0, a fresh job produces step_first=1 on its first issue.
REQ-043 tvalid toggling every other cycle -> identical act_col/wgt_row contents, step spacing 69 cycles.
